lcd_stream_driver: RTL and testbench
====================================

// Module: lcd_stream_driver
// PURPOSE
//  Converts a valid/ready RGB pixel stream into raster-ordered LCD writes (x, y, r, g, b) for a 480x272 panel.
//  Consumes one pixel per pixel tick during the active area and emits blanking and frame markers.
//  Sits between a frame source (framebuffer reader or pattern generator) and the LCD model/panel port.
// PARAMETERS
//  H_ACTIVE  480  active pixels per line
//  V_ACTIVE  272  active lines per frame
//  H_BLANK   40   blank pixel ticks per line
//  V_BLANK   8    blank lines per frame
//  PIX_DIV   1    clk cycles per pixel tick (>=1)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous active-high reset
//  enable      in   1   run raster; low forces IDLE
//  s_valid     in   1   stream beat valid
//  s_ready     out  1   stream beat accepted when s_valid&s_ready (combinational)
//  s_sof       in   1   beat is pixel (0,0) of a frame
//  s_rgb       in   24  {r,g,b} 8 bits each
//  lcd_x       out  10  column of current output pixel
//  lcd_y       out  10  row of current output pixel
//  lcd_r/g/b   out  8   pixel colour
//  lcd_de      out  1   output pixel is in the active area
//  lcd_vsync   out  1   high during vertical blank lines
//  frame_done  out  1   1-clk pulse when raster wraps to (0,0)
//  underflow   out  1   sticky: active tick with no valid beat
//  sync_err    out  1   sticky: s_sof accepted-candidate at non-origin
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, prescaler 0, sticky flags cleared. Same on rst mid-frame.
//  - tick: prescaler counts 0..PIX_DIV-1; tick=1 when it equals PIX_DIV-1; runs only in RUN.
//  - hcnt 0..H_ACTIVE+H_BLANK-1, vcnt 0..V_ACTIVE+V_BLANK-1; hcnt advances on tick, wraps -> vcnt++, vcnt wraps -> 0.
//  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE; origin = hcnt==0 && vcnt==0.
//  - FSM:
//    IDLE: s_ready=0; enable -> SYNC.
//    SYNC: s_ready = ~s_sof; non-sof beats discarded. s_valid&s_sof -> RUN with counters/prescaler 0.
//      That beat is not consumed here.
//    RUN: s_ready = tick & active & ~(s_sof & ~origin).
//      s_valid & s_sof & ~origin on an active tick -> sync_err=1, beat not consumed, next state SYNC,
//      counters reset, lcd_de=0.
//  - enable low in SYNC or RUN -> IDLE next clk; counters 0, lcd_de 0; stream beats are not consumed.
//  - Output latency 1 clk: on each RUN tick, register lcd_x<=hcnt, lcd_y<=vcnt, lcd_de<=active, lcd_vsync<=(vcnt>=V_ACTIVE).
//    Colour <= s_rgb if beat accepted; otherwise underflow fill.
//    Between ticks, outputs hold.
//  - Underflow: active tick with s_valid=0 -> underflow=1 (sticky until rst), colour fill, raster still advances (no stall).
//  - Blank ticks: colour 0, s_ready=0.
//  - frame_done: asserted the clk after the tick where hcnt and vcnt both wrap to 0.
//  - Simultaneous rst and enable: rst wins.
// CONFIGURATION
//  LCD_TESTPATTERN_EN defined:
//    underflow fill is a 24-pixel checkerboard.
//    {r,g,b} = {150,0,0} when (hcnt%48<24) == (vcnt%48<24), else 0.
//  LCD_TESTPATTERN_EN undefined: underflow fill is {0,0,0}.
// TESTING (bench params H_ACTIVE=8 V_ACTIVE=4 H_BLANK=2 V_BLANK=1 PIX_DIV=1)
//  1 Full frame: enable, stream 32 beats rgb=index, sof on 0 -> lcd_x/y sweep 0..7/0..3.
//    Colour equals index 1 clk after acceptance; underflow=0; frame_done once per 50 ticks.
//  2 Pre-sync junk: 3 non-sof beats then sof frame -> junk discarded (ready=1), first displayed pixel (0,0) = sof beat.
//  3 Underflow: drop s_valid for pixel (3,1).
//    -> underflow=1, colour 0 (or 150,0,0 with LCD_TESTPATTERN_EN), pixel (4,1) takes next beat.
//  4 Misaligned sof: s_sof at (5,2) -> s_ready=0, sync_err=1, SYNC.
//    Same beat then starts new frame at (0,0).
//  5 Blank/vsync: during hcnt 8..9 s_ready=0, lcd_de=0; line 4 -> lcd_vsync=1; PIX_DIV=3 -> ready pulses every 3rd clk.
//  6 Mid-frame rst at (6,2) -> next clk all outputs 0, flags cleared, state IDLE; enable low mid-frame -> IDLE, beats held.

Source files
------------

// File: rtl/lcd_stream_driver.sv
// lcd_stream_driver: valid/ready RGB stream to raster-ordered LCD pixel writes.
// Define LCD_TESTPATTERN_EN to fill underflowed pixels with a checkerboard.
module lcd_stream_driver #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int H_BLANK  = 40,
  parameter int V_BLANK  = 8,
  parameter int PIX_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [23:0] s_rgb,
  output logic [9:0]  lcd_x,
  output logic [9:0]  lcd_y,
  output logic [7:0]  lcd_r,
  output logic [7:0]  lcd_g,
  output logic [7:0]  lcd_b,
  output logic        lcd_de,
  output logic        lcd_vsync,
  output logic        frame_done,
  output logic        underflow,
  output logic        sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t        state_q, state_d;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d, vs_q, vs_d;
  logic          fd_q, fd_d, uf_q, uf_d, se_q, se_d;

  logic        tick, active, origin, accept, misalign;
  logic        hwrap, vwrap;
  logic [23:0] fill;

  assign tick   = (state_q == RUN) && (pre_q == PW'(PIX_DIV - 1));
  assign active = (hcnt_q < 10'(H_ACTIVE)) && (vcnt_q < 10'(V_ACTIVE));
  assign origin = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  assign hwrap  = (hcnt_q == 10'(H_TOTAL - 1));
  assign vwrap  = (vcnt_q == 10'(V_TOTAL - 1));
  assign accept = s_valid & s_ready;
  // a start-of-frame beat anywhere but the origin means the source slipped
  assign misalign = tick & active & s_valid & s_sof & ~origin;

`ifdef LCD_TESTPATTERN_EN
  assign fill = (((hcnt_q % 10'd48) < 10'd24) == ((vcnt_q % 10'd48) < 10'd24))
              ? 24'h960000 : 24'h000000;
`else
  assign fill = 24'h000000;
`endif

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      SYNC:    s_ready = enable & ~s_sof;
      RUN:     s_ready = enable & tick & active & ~(s_sof & ~origin);
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    pre_d   = pre_q;
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    vs_d    = vs_q;
    fd_d    = 1'b0;
    uf_d    = uf_q;
    se_d    = se_q;
    unique case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        pre_d  = '0;
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        if (!enable) begin
          state_d = IDLE;
          de_d    = 1'b0;
        end else if (s_valid && s_sof) begin
          state_d = RUN;
          hcnt_d  = '0;
          vcnt_d  = '0;
          pre_d   = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          hcnt_d  = '0;
          vcnt_d  = '0;
          pre_d   = '0;
          de_d    = 1'b0;
        end else if (!tick) begin
          pre_d = pre_q + PW'(1);
        end else begin
          pre_d = '0;
          if (misalign) begin
            se_d    = 1'b1;
            state_d = SYNC;
            hcnt_d  = '0;
            vcnt_d  = '0;
            de_d    = 1'b0;
          end else begin
            x_d   = hcnt_q;
            y_d   = vcnt_q;
            de_d  = active;
            vs_d  = (vcnt_q >= 10'(V_ACTIVE));
            rgb_d = accept ? s_rgb : (active ? fill : 24'h000000);
            if (active && !s_valid) uf_d = 1'b1;
            hcnt_d = hwrap ? 10'd0 : hcnt_q + 10'd1;
            if (hwrap) vcnt_d = vwrap ? 10'd0 : vcnt_q + 10'd1;
            fd_d = hwrap & vwrap;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pre_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      fd_q    <= 1'b0;
      uf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pre_q   <= pre_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      vs_q    <= vs_d;
      fd_q    <= fd_d;
      uf_q    <= uf_d;
      se_q    <= se_d;
    end
  end

  assign lcd_x      = x_q;
  assign lcd_y      = y_q;
  assign lcd_r      = rgb_q[23:16];
  assign lcd_g      = rgb_q[15:8];
  assign lcd_b      = rgb_q[7:0];
  assign lcd_de     = de_q;
  assign lcd_vsync  = vs_q;
  assign frame_done = fd_q;
  assign underflow  = uf_q;
  assign sync_err   = se_q;

endmodule

// File: tb/tb_lcd_stream_driver.sv
// tb_lcd_stream_driver: table vectors, directed corner cases and random
// stream traffic checked against a linear-index raster model.
module tb_lcd_stream_driver;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 2;
  localparam int VB = 1;
  localparam int HT = HA + HB;
  localparam int VT = VA + VB;
  localparam int NPIX = HT * VT;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_sof, s_ready;
  logic [23:0] s_rgb;
  logic [9:0]  lcd_x, lcd_y;
  logic [7:0]  lcd_r, lcd_g, lcd_b;
  logic        lcd_de, lcd_vsync, frame_done, underflow, sync_err;

  logic        en3, v3, sof3, rdy3;
  logic [23:0] rgb3;
  logic [9:0]  x3, y3;
  logic [7:0]  r3, g3, b3;
  logic        de3, vs3, fd3, uf3, se3;

  always #5 clk = ~clk;

  lcd_stream_driver #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                      .V_BLANK(VB), .PIX_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid),
    .s_ready(s_ready), .s_sof(s_sof), .s_rgb(s_rgb),
    .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_r(lcd_r), .lcd_g(lcd_g),
    .lcd_b(lcd_b), .lcd_de(lcd_de), .lcd_vsync(lcd_vsync),
    .frame_done(frame_done), .underflow(underflow), .sync_err(sync_err));

  lcd_stream_driver #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                      .V_BLANK(VB), .PIX_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .enable(en3), .s_valid(v3),
    .s_ready(rdy3), .s_sof(sof3), .s_rgb(rgb3),
    .lcd_x(x3), .lcd_y(y3), .lcd_r(r3), .lcd_g(g3),
    .lcd_b(b3), .lcd_de(de3), .lcd_vsync(vs3),
    .frame_done(fd3), .underflow(uf3), .sync_err(se3));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: mode 0 idle, 1 sync, 2 run; position is a linear tick index
  int          m_mode, m_pos;
  logic [9:0]  e_x, e_y;
  logic [23:0] e_rgb;
  logic        e_de, e_vs, e_fd, e_uf, e_se, e_ready;
  logic        seen_ready, last_acc;
  int          k;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [23:0] fill(input int x, input int y);
`ifdef LCD_TESTPATTERN_EN
    return (((x % 48) < 24) == ((y % 48) < 24)) ? 24'h960000 : 24'h0;
`else
    return 24'h0;
`endif
  endfunction

  function automatic logic [23:0] pix(input int i);
    return 24'h5A0000 | 24'(i);
  endfunction

  function automatic logic [48:0] dut_bus();
    return {lcd_x, lcd_y, lcd_r, lcd_g, lcd_b, lcd_de, lcd_vsync,
            frame_done, underflow, sync_err};
  endfunction

  function automatic logic [48:0] exp_bus();
    return {e_x, e_y, e_rgb, e_de, e_vs, e_fd, e_uf, e_se};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0;
    e_x = '0; e_y = '0; e_rgb = '0;
    e_de = 0; e_vs = 0; e_fd = 0; e_uf = 0; e_se = 0;
  endtask

  task automatic cyc(input logic r, input logic en, input logic v,
                     input logic sf, input logic [23:0] d);
    int  x, y;
    bit  act, org, tick;
    rst = r; enable = en; s_valid = v; s_sof = sf; s_rgb = d;
    #1;
    x = m_pos % HT;
    y = m_pos / HT;
    act = (x < HA) && (y < VA);
    org = (m_pos == 0);
    tick = (m_mode == 2);
    e_ready = 1'b0;
    if (en && m_mode == 1) e_ready = !sf;
    if (en && m_mode == 2) e_ready = tick && act && !(sf && !org);
    seen_ready = s_ready;
    chk("ready", 64'(s_ready), 64'(e_ready));
    last_acc = v && e_ready && !r && (m_mode == 2);
    e_fd = 1'b0;
    if (r) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (!en) begin
      m_mode = 0; m_pos = 0; e_de = 0;
    end else if (m_mode == 1) begin
      if (v && sf) begin m_mode = 2; m_pos = 0; end
    end else if (act && v && sf && !org) begin
      e_se = 1; m_mode = 1; m_pos = 0; e_de = 0;
    end else begin
      e_x = 10'(x); e_y = 10'(y); e_de = act; e_vs = (y >= VA);
      e_rgb = !act ? 24'h0 : (v ? d : fill(x, y));
      if (act && !v) e_uf = 1;
      m_pos = (m_pos + 1) % NPIX;
      if (m_pos == 0) e_fd = 1;
    end
    @(posedge clk);
    #1;
    chk("outputs", 64'(dut_bus()), 64'(exp_bus()));
  endtask

  task automatic feed_one(output logic acc, output int idx);
    idx = k;
    cyc(1'b0, 1'b1, 1'b1, (k == 0), pix(k));
    acc = last_acc;
    if (acc) k = (k + 1) % (HA * VA);
  endtask

  task automatic run_to(input int target, input string name);
    logic a;
    int   i;
    int   g;
    g = 0;
    while (m_pos != target && g < 200) begin
      feed_one(a, i);
      g++;
    end
    if (g >= 200) fail_now(name);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
    k = 0;
  endtask

  typedef struct {
    logic        en, v, sof;
    logic [23:0] d;
    logic        rdy, de;
    logic [9:0]  x, y;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic a;
    int   idx, fdc, off, g;
    en3 = 0; v3 = 0; sof3 = 0; rgb3 = '0;
    model_reset();

    // pre-sync junk is discarded; the sof beat is displayed at (0,0)
    tbl[0] = '{1, 0, 0, 24'h0,      0, 0, 0, 0, 24'h0};
    tbl[1] = '{1, 1, 0, 24'h111111, 1, 0, 0, 0, 24'h0};
    tbl[2] = '{1, 1, 0, 24'h222222, 1, 0, 0, 0, 24'h0};
    tbl[3] = '{1, 1, 0, 24'h333333, 1, 0, 0, 0, 24'h0};
    tbl[4] = '{1, 1, 1, 24'hABCDEF, 0, 0, 0, 0, 24'h0};
    tbl[5] = '{1, 1, 1, 24'hABCDEF, 1, 1, 0, 0, 24'hABCDEF};
    tbl[6] = '{1, 1, 0, 24'h010203, 1, 1, 1, 0, 24'h010203};

    do_reset();
    chk("reset_state", 64'(dut_bus()), 64'h0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, tbl[i].en, tbl[i].v, tbl[i].sof, tbl[i].d);
      chk("tbl_ready", 64'(seen_ready), 64'(tbl[i].rdy));
      chk("tbl_pix", 64'({lcd_de, lcd_x, lcd_y, lcd_r, lcd_g, lcd_b}),
          64'({tbl[i].de, tbl[i].x, tbl[i].y, tbl[i].rgb}));
    end

    // two full frames of indexed beats
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    fdc = 0;
    for (int c = 0; c < 2 * NPIX + 1; c++) begin
      feed_one(a, idx);
      if (frame_done) fdc++;
      if (a) begin
        chk("t1_rgb", 64'({lcd_r, lcd_g, lcd_b}), 64'(pix(idx)));
        chk("t1_xy", 64'({lcd_x, lcd_y}), 64'({10'(idx % HA), 10'(idx / HA)}));
      end
    end
    chk("t1_frame_done_count", 64'(fdc), 64'd2);
    chk("t1_no_underflow", 64'(underflow), 64'd0);

    // underflow at (3,1); (4,1) takes the withheld beat
    run_to(13, "t3_reach");
    idx = k;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("t3_underflow", 64'(underflow), 64'd1);
    chk("t3_fill", 64'({lcd_x, lcd_y, lcd_r, lcd_g, lcd_b}),
        64'({10'd3, 10'd1, fill(3, 1)}));
    feed_one(a, off);
    chk("t3_next", 64'({lcd_x, lcd_r, lcd_g, lcd_b}), 64'({10'd4, pix(idx)}));

    // misaligned sof at (5,2)
    run_to(25, "t4_reach");
    k = 0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, pix(0));
    chk("t4_ready_low", 64'(seen_ready), 64'd0);
    chk("t4_sync_err", 64'({sync_err, lcd_de}), 64'({1'b1, 1'b0}));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, pix(0));
    chk("t4_sync_ready", 64'(seen_ready), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, pix(0));
    chk("t4_restart", 64'({seen_ready, lcd_x, lcd_y, lcd_r, lcd_g, lcd_b}),
        64'({1'b1, 10'd0, 10'd0, pix(0)}));
    k = 1;

    // horizontal blank and vertical blank line
    run_to(8, "t5_hblank");
    feed_one(a, idx);
    chk("t5_hblank", 64'({seen_ready, lcd_de, lcd_x}), 64'({1'b0, 1'b0, 10'd8}));
    run_to(40, "t5_vblank");
    feed_one(a, idx);
    chk("t5_vsync", 64'({lcd_vsync, lcd_de, lcd_y}), 64'({1'b1, 1'b0, 10'd4}));

    // mid-frame reset at (6,2)
    run_to(26, "t6_reach");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, pix(k));
    chk("t6_rst_clear", 64'(dut_bus()), 64'h0);
    k = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    run_to(5, "t6_resync");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, pix(k));
    chk("t6_en_low", 64'({seen_ready, lcd_de}), 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, pix(k));
    chk("t6_held", 64'(seen_ready), 64'd0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r, en, v, sf;
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 79) != 0);
      v  = ($urandom_range(0, 9) != 0);
      sf = (k == 0) ^ ($urandom_range(0, 59) == 0);
      cyc(r, en, v, sf, v ? 24'($urandom) : 24'h0);
      if (r) k = 0;
      else if (last_acc) k = (k + 1) % (HA * VA);
    end

    // PIX_DIV=3: one tick every third clock
    rst = 1'b0; enable = 1'b0;
    en3 = 1; v3 = 1; sof3 = 1; rgb3 = 24'h123456;
    g = 0;
    #1;
    while (!rdy3 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 20) fail_now("t5_div3_first");
    chk("t5_div3_latency", 64'(g), 64'd4);
    @(posedge clk); #1;
    chk("t5_div3_pix0", 64'({x3, r3, g3, b3}), 64'({10'd0, 24'h123456}));
    sof3 = 0;
    for (off = 1; off <= 15; off++) begin
      rgb3 = 24'(off);
      #1;
      chk("t5_div3_ready", 64'(rdy3), 64'(off % 3 == 0));
      @(posedge clk); #1;
      chk("t5_div3_x", 64'(x3), 64'(off / 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
